// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the single-issue MIPS datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB over a shared bus, trapping on illegal opcodes and bus timeouts.
module mc_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       br_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       i_or_r,
  output logic       reg_write,
  output logic       load,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_error
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t        st_q, st_next;
  logic [CW-1:0] cnt;
  logic [5:0]    op_q, funct_q;
  logic          dec_legal;
  logic          bus_wait;
  logic          timeout;
  logic          is_add_q;

  always_comb begin
    dec_legal = 1'b0;
    case (op)
      OP_ADDI, OP_LW, OP_SW, OP_BGTZ, OP_J: dec_legal = 1'b1;
      OP_RTYPE:                             dec_legal = (funct == FN_ADD);
      default:                              dec_legal = 1'b0;
    endcase
  end

  assign is_add_q = (op_q == OP_RTYPE) && (funct_q == FN_ADD);
  assign bus_wait = ((st_q == S_FETCH) || (st_q == S_MEM)) && !mem_ready;
  assign timeout  = (TIMEOUT != 0) && bus_wait && (cnt == TMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= S_FETCH;
    else     st_q <= st_next;
  end

  always_comb begin
    st_next = st_q;
    case (st_q)
      S_FETCH: begin
        if (mem_ready)    st_next = S_DECODE;
        else if (timeout) st_next = S_TRAP;
      end
      S_DECODE: begin
        if (!dec_legal)        st_next = S_TRAP;
        else if (op == OP_J)   st_next = S_FETCH;
        else                   st_next = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADDI, OP_RTYPE: st_next = S_WB;
          OP_LW, OP_SW:      st_next = S_MEM;
          default:           st_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)    st_next = (op_q == OP_LW) ? S_WB : S_FETCH;
        else if (timeout) st_next = S_TRAP;
      end
      S_WB:    st_next = S_FETCH;
      S_TRAP:  st_next = S_TRAP;
      default: st_next = S_FETCH;
    endcase
  end

  // Every state change re-arms the wait counter; only FETCH/MEM ever let it count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      funct_q   <= '0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (st_next != st_q)             cnt <= '0;
      else if (bus_wait && cnt != '1)  cnt <= cnt + 1'b1;
      if (st_q == S_DECODE) begin
        op_q    <= op;
        funct_q <= funct;
        if (!dec_legal) illegal <= 1'b1;
      end
      if (timeout) bus_error <= 1'b1;
    end
  end

  // DECODE decides J from the live opcode since op_q is only being captured this cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    alu_op    = 3'd0;
    i_or_r    = 1'b0;
    reg_write = 1'b0;
    load      = 1'b0;
    if (!rst) begin
      case (st_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (op == OP_J) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
        end
        S_EXEC: begin
          if (op_q == OP_BGTZ) begin
            alu_op   = 3'd7;
            pc_write = br_cond;
            pc_src   = 2'd1;
          end else begin
            alu_op = 3'd1;
          end
          i_or_r = is_add_q;
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (op_q == OP_SW);
          alu_op   = 3'd1;
        end
        S_WB: begin
          reg_write = 1'b1;
          load      = (op_q == OP_LW);
          alu_op    = 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: cycle-level vector table plus
// hand-written sequences for trap, timeout and reset corner cases.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       br_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic       i_or_r, reg_write, load;
  logic [2:0] state;
  logic       illegal, bus_error;

  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] RTYP = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BGTZ = 6'b000111;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] FADD = 6'b100000;
  localparam logic [5:0] FSUB = 6'b100010;

  mc_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .br_cond(br_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_op(alu_op), .i_or_r(i_or_r),
    .reg_write(reg_write), .load(load), .state(state),
    .illegal(illegal), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {state, mem_req, mem_we, addr_sel, ir_write, pc_write,
                pc_src, alu_op, i_or_r, reg_write, load};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        br;
    logic        rdy;
    logic [15:0] exp;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  function automatic logic [15:0] ex(int st, int req, int we, int as, int irw,
                                     int pcw, int src, int alu, int ior,
                                     int rw, int ld);
    return {3'(st), 1'(req), 1'(we), 1'(as), 1'(irw), 1'(pcw),
            2'(src), 3'(alu), 1'(ior), 1'(rw), 1'(ld)};
  endfunction

  task automatic addv(input logic [5:0] o, input logic [5:0] f,
                      input logic b, input logic r, input logic [15:0] e);
    vec_t v;
    v.op = o; v.fn = f; v.br = b; v.rdy = r; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_flags", {30'd0, illegal, bus_error}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int cnt;
  int errs;
  bit done;

  initial begin
    // ADDI, op changed after DECODE must not matter
    addv(ADDI, 6'd0, 0, 1, ex(0,1,0,0,1,1,0,0,0,0,0));
    addv(ADDI, 6'd0, 0, 1, ex(1,0,0,0,0,0,0,0,0,0,0));
    addv(LW,   6'd0, 0, 1, ex(2,0,0,0,0,0,0,1,0,0,0));
    addv(JMP,  6'd0, 0, 1, ex(4,0,0,0,0,0,0,1,0,1,0));
    // ADD
    addv(RTYP, FADD, 0, 1, ex(0,1,0,0,1,1,0,0,0,0,0));
    addv(RTYP, FADD, 0, 1, ex(1,0,0,0,0,0,0,0,0,0,0));
    addv(RTYP, FADD, 0, 1, ex(2,0,0,0,0,0,0,1,1,0,0));
    addv(RTYP, FADD, 0, 1, ex(4,0,0,0,0,0,0,1,0,1,0));
    // LW, two MEM wait cycles
    addv(LW, 6'd0, 0, 1, ex(0,1,0,0,1,1,0,0,0,0,0));
    addv(LW, 6'd0, 0, 1, ex(1,0,0,0,0,0,0,0,0,0,0));
    addv(LW, 6'd0, 0, 1, ex(2,0,0,0,0,0,0,1,0,0,0));
    addv(LW, 6'd0, 0, 0, ex(3,1,0,1,0,0,0,1,0,0,0));
    addv(LW, 6'd0, 0, 0, ex(3,1,0,1,0,0,0,1,0,0,0));
    addv(LW, 6'd0, 0, 1, ex(3,1,0,1,0,0,0,1,0,0,0));
    addv(LW, 6'd0, 0, 1, ex(4,0,0,0,0,0,0,1,0,1,1));
    // SW zero wait
    addv(SW, 6'd0, 0, 1, ex(0,1,0,0,1,1,0,0,0,0,0));
    addv(SW, 6'd0, 0, 1, ex(1,0,0,0,0,0,0,0,0,0,0));
    addv(SW, 6'd0, 0, 1, ex(2,0,0,0,0,0,0,1,0,0,0));
    addv(SW, 6'd0, 0, 1, ex(3,1,1,1,0,0,0,1,0,0,0));
    // J with one FETCH wait
    addv(JMP, 6'd0, 0, 0, ex(0,1,0,0,0,0,0,0,0,0,0));
    addv(JMP, 6'd0, 0, 1, ex(0,1,0,0,1,1,0,0,0,0,0));
    addv(JMP, 6'd0, 0, 1, ex(1,0,0,0,0,1,2,0,0,0,0));
    // BGTZ taken, then not taken
    addv(BGTZ, 6'd0, 1, 1, ex(0,1,0,0,1,1,0,0,0,0,0));
    addv(BGTZ, 6'd0, 1, 1, ex(1,0,0,0,0,0,0,0,0,0,0));
    addv(BGTZ, 6'd0, 1, 1, ex(2,0,0,0,0,1,1,7,0,0,0));
    addv(BGTZ, 6'd0, 0, 1, ex(0,1,0,0,1,1,0,0,0,0,0));
    addv(BGTZ, 6'd0, 1, 1, ex(1,0,0,0,0,0,0,0,0,0,0));
    addv(BGTZ, 6'd0, 0, 1, ex(2,0,0,0,0,0,1,7,0,0,0));
    addv(ADDI, 6'd0, 0, 0, ex(0,1,0,0,0,0,0,0,0,0,0));

    #2;
    do_reset();
    foreach (vq[i]) begin
      op = vq[i].op; funct = vq[i].fn; br_cond = vq[i].br; mem_ready = vq[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {16'd0, obs}, {16'd0, vq[i].exp});
      tick();
    end

    // Illegal ADD funct traps and stays off the bus
    br_cond = 1'b0;
    do_reset();
    op = RTYP; funct = FSUB; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("ill_decode", {28'd0, illegal, state}, {28'd0, 1'b0, 3'd1});
    tick();
    @(negedge clk);
    chk("ill_trap", {28'd0, illegal, state}, {28'd0, 1'b1, 3'd5});
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (mem_req !== 1'b0 || state !== 3'd5 || illegal !== 1'b1) errs++;
    end
    chk("ill_hold", errs, 0);
    do_reset();

    // FETCH timeout: 16 request cycles then TRAP
    op = ADDI; funct = '0; mem_ready = 1'b0;
    cnt = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (state == 3'd5) done = 1;
      else begin
        if (mem_req) cnt++;
        tick();
      end
    end
    chk("tmo_reached", {31'd0, done}, 32'd1);
    chk("tmo_cycles", cnt, 16);
    chk("tmo_flags", {30'd0, bus_error, illegal}, {30'd0, 1'b1, 1'b0});
    do_reset();

    // mem_ready on the 16th cycle beats the timeout
    mem_ready = 1'b0;
    repeat (15) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("late_rdy_fetch", {29'd0, state, ir_write, pc_write}, {27'd0, 3'd0, 1'b1, 1'b1});
    tick();
    @(negedge clk);
    chk("late_rdy_decode", {28'd0, bus_error, state}, {28'd0, 1'b0, 3'd1});
    do_reset();

    // Wait counter re-arms between FETCH and MEM
    op = SW; mem_ready = 1'b0;
    repeat (10) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rearm_mem", {29'd0, state}, 32'd3);
    tick();
    repeat (10) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rearm_we", {30'd0, mem_we, bus_error}, {30'd0, 1'b1, 1'b0});
    tick();
    @(negedge clk);
    chk("rearm_back", {28'd0, bus_error, state}, {28'd0, 1'b0, 3'd0});
    do_reset();

    // Reset mid-MEM drops the request immediately
    op = LW; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #2;
    chk("mid_mem_pre", {28'd0, mem_req, state}, {28'd0, 1'b1, 3'd3});
    rst = 1'b1;
    #1;
    chk("mid_mem_rst", {28'd0, mem_req, state}, {28'd0, 1'b0, 3'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
